// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default SRAM base address and halfword-select constants.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } mem_state_e;

   localparam int unsigned DEFAULT_BASE_ADDR = 32'd1024;

   localparam logic LO_HALF = 1'b0;
   localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase wait counter for the SRAM controller: counts 0..WAIT_CYCLES-1
// while enabled, flags the last cycle and pulses done as the phase ends.
module sram_phase_timer
   import arm_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_en,
   output logic o_last,
   output logic o_done
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   // Counter wraps on its own at the end of a phase so LO hands over to HI at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_start) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_last = (r_cnt == LAST_CNT);
   assign o_done = i_en & o_last;

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit async SRAM phases,
// holding ready low meanwhile. Optional macro ADDR_RANGE_CHECK_EN rejects out-of-range requests.
module sram_mem_ctrl
   import arm_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 5,
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_o,
   input  logic [15:0]        sram_dq_i,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output logic               addr_err
);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_LO   = LO;
   localparam logic [1:0] S_HI   = HI;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]         r_state;
   logic [SRAM_AW-2:0] r_idx;
   logic [31:0]        r_wdata;
   logic               r_wr;
   logic [31:0]        r_rdata;

   logic [31:0]        w_off;
   logic [SRAM_AW-2:0] w_idx;
   logic               w_req;
   logic               w_bad;
   logic               w_accept;
   logic               w_phase;
   logic               w_half;
   logic               w_last;
   logic               w_done;
   logic               w_unused_bits;

   assign w_off = address - BASE_ADDR;
   assign w_idx = w_off[SRAM_AW:2];
   assign w_req = rd_en | wr_en;

`ifdef ADDR_RANGE_CHECK_EN
   logic r_addr_err;

   assign w_bad         = (address < BASE_ADDR) || (|w_off[31:SRAM_AW+1]);
   assign w_unused_bits = ^w_off[1:0];
   assign addr_err      = r_addr_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= (r_state == S_IDLE) & w_req & w_bad;
      end
   end
`else
   assign w_bad         = 1'b0;
   assign w_unused_bits = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
   assign addr_err      = 1'b0;
`endif

   assign w_accept = (r_state == S_IDLE) & w_req & ~w_bad;
   assign ready    = ((r_state == S_IDLE) & ~w_accept) | (r_state == S_DONE);
   assign w_phase  = (r_state == S_LO) | (r_state == S_HI);
   assign w_half   = (r_state == S_HI) ? HI_HALF : LO_HALF;
   assign rdata    = r_rdata;

   sram_phase_timer #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_start((r_state == S_IDLE) | (r_state == S_DONE)),
      .i_en   (w_phase),
      .o_last (w_last),
      .o_done (w_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_wdata <= '0;
         r_wr    <= 1'b0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_idx   <= w_idx;
                  r_wdata <= wdata;
                  r_wr    <= wr_en;
                  r_state <= S_LO;
               end else if (w_req & w_bad & ~wr_en) begin
                  r_rdata <= '0;
               end
            end
            S_LO: begin
               if (w_done) begin
                  if (!r_wr) r_rdata[15:0] <= sram_dq_i;
                  r_state <= S_HI;
               end
            end
            S_HI: begin
               if (w_done) begin
                  if (!r_wr) r_rdata[31:16] <= sram_dq_i;
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write strobe is released on the last cycle of each phase to give data hold
   always_comb begin
      sram_addr  = '0;
      sram_dq_o  = '0;
      sram_dq_oe = 1'b0;
      sram_we_n  = 1'b1;
      if (w_phase) begin
         sram_addr = {r_idx, w_half};
         if (r_wr) begin
            sram_dq_o  = (w_half == HI_HALF) ? r_wdata[31:16] : r_wdata[15:0];
            sram_dq_oe = 1'b1;
            sram_we_n  = w_last;
         end
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl with a behavioural async SRAM model.
module tb_sram_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] address, wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_we_n, addr_err;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic        is_rd;
      int          lo;
      logic [31:0] data;
      string       tag;
   } exp_t;
   exp_t sb[$];

   logic [15:0] mem [0:63];

   always #5 clk = ~clk;

   sram_mem_ctrl #(
      .WAIT_CYCLES(5),
      .BASE_ADDR  (1024),
      .SRAM_AW    (18)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .wr_en     (wr_en),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .ready     (ready),
      .sram_addr (sram_addr),
      .sram_dq_o (sram_dq_o),
      .sram_dq_i (sram_dq_i),
      .sram_dq_oe(sram_dq_oe),
      .sram_we_n (sram_we_n),
      .addr_err  (addr_err)
   );

   assign sram_dq_i = mem[sram_addr[5:0]];

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_o;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor: counts ready-low cycles and retires one scoreboard entry per completion
   int low_cnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         low_cnt = 0;
      end else if (!ready) begin
         low_cnt++;
      end else if (low_cnt > 0) begin
         if (sb.size() == 0) begin
            chk("unexpected_completion", 32'(low_cnt), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_ready_low_cycles"}, 32'(low_cnt), 32'd11);
            if (e.is_rd)
               chk({e.tag, "_rdata"}, rdata, e.data);
            else
               chk({e.tag, "_mem"}, {mem[e.lo + 1], mem[e.lo]}, e.data);
         end
         low_cnt = 0;
      end
   end

   task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int exp_lo,
                             input logic [31:0] exp_data, input string tag);
      exp_t e;
      int   k;
      e.is_rd = rd & ~wr;
      e.lo    = exp_lo;
      e.data  = exp_data;
      e.tag   = tag;
      sb.push_back(e);
      rd_en   = rd;
      wr_en   = wr;
      address = addr;
      wdata   = wd;
      #1;
      chk({tag, "_ready_on_request"}, 32'(ready), 32'd0);
      tick;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      address = 32'hFFFF_FFF0;
      wdata   = 32'h0BAD_F00D;
      k = 0;
      while (!ready && k < 40) begin
         chk({tag, "_sram_addr"}, 32'(sram_addr), 32'(exp_lo + ((k >= 5) ? 1 : 0)));
         if (wr) begin
            chk({tag, "_we_n"}, 32'(sram_we_n), 32'((k % 5) == 4));
            chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd1);
            chk({tag, "_dq_o"}, 32'(sram_dq_o), (k < 5) ? 32'(wd[15:0]) : 32'(wd[31:16]));
         end else begin
            chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
            chk({tag, "_dq_oe"}, 32'(sram_dq_oe), 32'd0);
         end
         tick;
         k++;
      end
      chk({tag, "_busy_cycles_after_latch"}, 32'(k), 32'd10);
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[0] = 16'h1111;
      mem[1] = 16'h2222;
      mem[8] = 16'h3333;
      mem[9] = 16'h4444;
      rst     = 1'b1;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      address = 32'd0;
      wdata   = 32'd0;
      tick;
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_we_n", 32'(sram_we_n), 32'd1);
      chk("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
      chk("reset_sram_addr", 32'(sram_addr), 32'd0);
      chk("reset_dq_o", 32'(sram_dq_o), 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_addr_err", 32'(addr_err), 32'd0);
      rst = 1'b0;

      // Idle for 20 cycles
      for (int i = 0; i < 20; i++) begin
         tick;
         chk("idle_ready", 32'(ready), 32'd1);
         chk("idle_we_n", 32'(sram_we_n), 32'd1);
         chk("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
         chk("idle_rdata", rdata, 32'd0);
         chk("idle_addr_err", 32'(addr_err), 32'd0);
      end

      run_access(1'b1, 1'b0, 32'd1024, 32'd0, 0, 32'h2222_1111, "load1024");
      run_access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, "store1028");
      chk("store_keeps_rdata", rdata, 32'h2222_1111);

      // Reset in the middle of a load
      rd_en   = 1'b1;
      address = 32'd1040;
      tick;
      rd_en = 1'b0;
      tick;
      tick;
      tick;
      chk("abort_busy", 32'(ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_rdata", rdata, 32'd0);
      chk("abort_sram_addr", 32'(sram_addr), 32'd0);
      tick;
      rst = 1'b0;
      tick;
      run_access(1'b1, 1'b0, 32'd1040, 32'd0, 8, 32'h4444_3333, "load1040");

      // Back-to-back store then load; both enables on the store so write wins
      run_access(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, "store1032");
      run_access(1'b1, 1'b0, 32'd1032, 32'd0, 4, 32'hCAFE_F00D, "load1032");

`ifdef ADDR_RANGE_CHECK_EN
      rd_en   = 1'b1;
      address = 32'd256;
      #1;
      chk("range_ready", 32'(ready), 32'd1);
      chk("range_sram_addr", 32'(sram_addr), 32'd0);
      tick;
      rd_en = 1'b0;
      chk("range_addr_err", 32'(addr_err), 32'd1);
      chk("range_rdata", rdata, 32'd0);
      chk("range_ready_after", 32'(ready), 32'd1);
      tick;
      chk("range_addr_err_clear", 32'(addr_err), 32'd0);
`endif

      tick;
      tick;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
